multi_queue: RTL and testbench
==============================

# multi_queue

Multi-lane in-order FIFO: accepts up to ENQ_W entries and releases up to DEQ_W entries per cycle over arrays of `decoupled` channels. Successor to the single-lane queue for superscalar paths (fetch→decode, decode→rename, commit buffers). Adds arbitrary non-power-of-two DEPTH, full use of all DEPTH slots, occupancy outputs and a synchronous flush. No fallthrough mode.

## Interface
- `Data`, `gpreg`: entry type.
- `DEPTH`, 8: number of slots. Any integer ≥ max(ENQ_W, DEQ_W); need not be a power of two.
- `ENQ_W`, 2: enqueue lanes, ≥1.
- `DEQ_W`, 2: dequeue lanes, ≥1.
- `PIPE`, 0: when 1, slots freed by this cycle's dequeue count toward this cycle's enqueue readiness.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  synchronous clear of all contents.
- `enq[ENQ_W]`  decoupled.in  Data  enqueue lanes; lane 0 is oldest.
- `deq[DEQ_W]`  decoupled.out  Data  dequeue lanes; lane 0 is head.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `free`  out  $clog2(DEPTH+1)  DEPTH − count.

## Operation
- State: `store[DEPTH]`, `head`, `tail` in 0..DEPTH−1, `count` in 0..DEPTH. Full and empty come from `count`, never from pointer equality, so all DEPTH slots are usable.
- Enqueue lanes are prefix-valid: `enq[i].valid` implies `enq[i-1].valid`. A violation is a protocol error; the bench asserts on it.
- `enq[i].ready = (avail > i)`. `avail = free` when PIPE=0, `free + n_deq` when PIPE=1. Ready does not depend on `enq.valid`.
- `n_enq` = number of lanes with valid&&ready. This is always a prefix.
- `deq[i].valid = (count > i)`. `deq[i].data = store[(head+i) mod DEPTH]`.
- Dequeue readiness must be prefix-shaped: consumer `ready[i]` implies `ready[i-1]`. A violation is a protocol error.
- `n_deq` = number of lanes with valid&&ready.
- Writes: for each i < n_enq, `store[(tail+i) mod DEPTH] <= enq[i].data`.
- Pointer update: `tail <= (tail+n_enq) mod DEPTH`, `head <= (head+n_deq) mod DEPTH`, `count <= count + n_enq − n_deq`.
- Modular add is computed as sum, minus DEPTH if sum ≥ DEPTH. Sum width is $clog2(DEPTH)+1. No reliance on natural wrap.
- Simultaneous enqueue and dequeue are both applied.
- PIPE=1 with count=DEPTH: incoming entries may fill slots vacated by the same cycle's dequeue. This adds a combinational path deq.ready→enq.ready; document it at the instantiation site.
- `flush` drops everything: head, tail and count go to 0. Any enqueue or dequeue handshake in that cycle is ignored. Store writes are suppressed in a flush cycle.
- `rst` has priority over `flush`; it behaves identically to flush.

## Timing
- Reset values (cycle after `rst` is sampled high):
  - head=tail=count=0, free=DEPTH.
  - All `deq[i].valid`=0.
  - All `enq[i].ready`=1 (DEPTH ≥ ENQ_W).
  - Store contents undefined and never exposed.
- Latency: an entry enqueued in cycle t is visible on `deq[0]` at cycle t+1 at the earliest. There is no same-cycle bypass.
- `count`, `free`, `deq.valid` are registered-state functions; none depends combinationally on any input.
- With PIPE=0, `enq.ready` has no input dependency. With PIPE=1 it depends on `deq.ready` only.
- Throughput: sustained min(ENQ_W, DEQ_W) entries per cycle when DEPTH ≥ ENQ_W + DEQ_W.
- `rst` or `flush` asserted mid-burst: state is empty on the next cycle. Entries offered that cycle are lost; the producer is responsible for replay.

## Structure
- Shared package (`types.sv`) gets `queue_cnt_t` sizing via a `$clog2(DEPTH+1)` localparam helper function. Idx and count widths are derived locally from DEPTH.
- One sub-module, `fire_count`: width-parameterised prefix popcount of a valid&&ready vector. It is instantiated twice, for n_enq and n_deq.
- Modular pointer add is a local function, not a module.

## Test plan
- Reset then idle, DEPTH=6, ENQ_W=DEQ_W=2:
  - count=0, free=6.
  - `deq[*].valid`=0, `enq[*].ready`=1.
- Enqueue A,B, then C,D, then E,F with no dequeue:
  - count=6.
  - `enq[0].ready`=0 and `deq[0..1]`=A,B.
- Wrap-around, DEPTH=6, alternating 2-in/1-out for 20 cycles:
  - Pointers wrap through 5→0.
  - Output order matches a scoreboard; count never exceeds 6.
- Full queue, PIPE=1, deq ready on both lanes with 2 enqueues offered:
  - Both enqueues accepted the same cycle.
  - count stays 6; PIPE=0 run of the same case accepts 0.
- Partial dequeue, count=3, `deq` ready prefix of 1 with 2 enqueues:
  - n_deq=1, n_enq=2, count=4 next cycle.
- Flush with 4 entries and simultaneous enq/deq handshakes:
  - Next cycle count=0 and `deq[0].valid`=0.
  - Subsequent enqueue X appears on `deq[0]` one cycle later.

Source files
------------

// File: rtl/multi_queue_pkg.sv
// -----------------------------------------------------------------------------
// multi_queue_pkg
// Shared types and sizing helpers for the multi-lane in-order queue.
//   gpreg      : default entry type carried by the queue lanes
//   cnt_width  : width needed to hold an occupancy in 0..depth
//   idx_width  : width needed to hold a slot index in 0..depth-1 (min 1)
// -----------------------------------------------------------------------------
package multi_queue_pkg;

  typedef logic [31:0] gpreg;

  localparam int DEFAULT_DEPTH = 8;

  // Occupancy runs 0..depth inclusive, so one extra code point is needed.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Slot index runs 0..depth-1; a depth of 1 still needs a 1-bit pointer.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : multi_queue_pkg

// File: rtl/multi_queue_fire_count.sv
// -----------------------------------------------------------------------------
// multi_queue_fire_count
// Prefix popcount of a per-lane fire (valid && ready) vector: the number of
// consecutive set bits starting at lane 0. Lanes above the first clear bit are
// ignored, which keeps the result a contiguous prefix of lanes.
// Ports:
//   i_fire  [W]   per-lane handshake vector, lane 0 oldest
//   o_count [CW]  length of the leading run of ones (0..W)
// -----------------------------------------------------------------------------
module multi_queue_fire_count #(
  parameter  int W  = 2,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_fire,
  output logic [CW-1:0] o_count
);

  logic w_run;

  always_comb begin
    o_count = '0;
    w_run   = 1'b1;
    for (int i = 0; i < W; i++) begin
      w_run   = w_run & i_fire[i];
      o_count = o_count + CW'(w_run);
    end
  end

endmodule : multi_queue_fire_count

// File: rtl/multi_queue.sv
// -----------------------------------------------------------------------------
// multi_queue
// Multi-lane in-order FIFO. Accepts up to ENQ_W entries and releases up to
// DEQ_W entries per cycle. DEPTH need not be a power of two and every slot is
// usable because full/empty are derived from the occupancy counter rather than
// from pointer equality. No fallthrough: an entry written in cycle t is first
// visible on deq lane 0 in cycle t+1.
//
// Parameters:
//   Data   entry type
//   DEPTH  number of slots (>= max(ENQ_W, DEQ_W))
//   ENQ_W  enqueue lanes, DEQ_W dequeue lanes
//   PIPE   1: slots freed by this cycle's dequeue are offered to this cycle's
//          enqueue. This creates a combinational path deq_ready -> enq_ready
//          that the instantiating block must account for in timing.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   flush            synchronous clear; handshakes in a flush cycle are dropped
//   enq_valid/ready/data [ENQ_W]   producer lanes, lane 0 oldest, prefix-valid
//   deq_valid/ready/data [DEQ_W]   consumer lanes, lane 0 head, prefix-ready
//   count            occupancy (registered state only)
//   free             DEPTH - count (registered state only)
// -----------------------------------------------------------------------------
module multi_queue
  import multi_queue_pkg::*;
#(
  parameter  type Data  = gpreg,
  parameter  int  DEPTH = DEFAULT_DEPTH,
  parameter  int  ENQ_W = 2,
  parameter  int  DEQ_W = 2,
  parameter  int  PIPE  = 0,
  localparam int  CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [ENQ_W-1:0] enq_valid,
  output logic [ENQ_W-1:0] enq_ready,
  input  Data              enq_data [ENQ_W],
  output logic [DEQ_W-1:0] deq_valid,
  input  logic [DEQ_W-1:0] deq_ready,
  output Data              deq_data [DEQ_W],
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] free
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int SUM_W = IDX_W + 1;
  localparam int EW    = $clog2(ENQ_W + 1);
  localparam int DW    = $clog2(DEQ_W + 1);
  localparam int AV_W  = CNT_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  Data              r_store [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [CNT_W-1:0] w_free;
  logic [AV_W-1:0]  w_avail;
  logic [ENQ_W-1:0] w_enq_fire;
  logic [DEQ_W-1:0] w_deq_fire;
  logic [EW-1:0]    w_n_enq;
  logic [DW-1:0]    w_n_deq;
  logic             w_clear;

  // Modular pointer add without relying on natural binary wrap: base is below
  // DEPTH and inc is at most DEPTH, so one conditional subtract suffices and
  // the sum never overflows SUM_W bits.
  function automatic logic [IDX_W-1:0] ptr_add(input logic [IDX_W-1:0] base,
                                               input logic [SUM_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, base} + inc;
    if (sum >= SUM_W'(DEPTH)) begin
      sum = sum - SUM_W'(DEPTH);
    end
    return sum[IDX_W-1:0];
  endfunction

  assign w_clear = rst | flush;
  assign w_free  = CNT_W'(DEPTH) - r_count;
  assign count   = r_count;
  assign free    = w_free;

  // ---------------------------------------------------------------------------
  // Dequeue side: valid and data are pure functions of registered state.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEQ_W; gi++) begin : g_deq
      assign deq_valid[gi]  = (r_count > CNT_W'(gi));
      assign deq_data[gi]   = r_store[ptr_add(r_head, SUM_W'(gi))];
      assign w_deq_fire[gi] = deq_valid[gi] & deq_ready[gi];
    end
  endgenerate

  multi_queue_fire_count #(
    .W (DEQ_W)
  ) u_deq_count (
    .i_fire  (w_deq_fire),
    .o_count (w_n_deq)
  );

  // ---------------------------------------------------------------------------
  // Enqueue side: readiness never looks at enq_valid. With PIPE the slots being
  // vacated this cycle are added to the free space, which is the only input
  // dependency of enq_ready.
  // ---------------------------------------------------------------------------
  generate
    if (PIPE != 0) begin : g_avail_pipe
      assign w_avail = {1'b0, w_free} + AV_W'(w_n_deq);
    end else begin : g_avail_plain
      assign w_avail = {1'b0, w_free};
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < ENQ_W; gi++) begin : g_enq
      assign enq_ready[gi]  = (w_avail > AV_W'(gi));
      assign w_enq_fire[gi] = enq_valid[gi] & enq_ready[gi];
    end
  endgenerate

  multi_queue_fire_count #(
    .W (ENQ_W)
  ) u_enq_count (
    .i_fire  (w_enq_fire),
    .o_count (w_n_enq)
  );

  // ---------------------------------------------------------------------------
  // Pointer and occupancy update. Reset and flush both empty the queue and
  // discard any handshake offered in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= ptr_add(r_head, SUM_W'(w_n_deq));
      r_tail  <= ptr_add(r_tail, SUM_W'(w_n_enq));
      r_count <= r_count + CNT_W'(w_n_enq) - CNT_W'(w_n_deq);
    end
  end

  // Storage writes: the accepted prefix of enqueue lanes lands at consecutive
  // slots from the tail. Contents are never cleared; they are only exposed
  // through deq_data while the matching deq_valid is high.
  always_ff @(posedge clk) begin
    if (!w_clear) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (EW'(i) < w_n_enq) begin
          r_store[ptr_add(r_tail, SUM_W'(i))] <= enq_data[i];
        end
      end
    end
  end

endmodule : multi_queue

// File: tb/tb_multi_queue.sv
// -----------------------------------------------------------------------------
// tb_multi_queue
// Drives two queues (DEPTH=6, 2+2 lanes) with identical inputs, one with
// PIPE=0 and one with PIPE=1, and compares every output against a per-queue
// reference model built on an SV queue of entries.
// -----------------------------------------------------------------------------
module tb_multi_queue;
  import multi_queue_pkg::*;

  localparam int D = 6;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] enq_valid;
  gpreg       enq_data [2];
  logic [1:0] deq_ready;

  logic [1:0] enq_ready_o [2];
  logic [1:0] deq_valid_o [2];
  gpreg       deq_data_o  [2][2];
  logic [2:0] count_o     [2];
  logic [2:0] free_o      [2];

  multi_queue #(.Data(gpreg), .DEPTH(D), .ENQ_W(2), .DEQ_W(2), .PIPE(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready_o[0]),
    .enq_data  (enq_data),
    .deq_valid (deq_valid_o[0]),
    .deq_ready (deq_ready),
    .deq_data  (deq_data_o[0]),
    .count     (count_o[0]),
    .free      (free_o[0])
  );

  // PIPE=1 instance: deq_ready feeds enq_ready combinationally.
  multi_queue #(.Data(gpreg), .DEPTH(D), .ENQ_W(2), .DEQ_W(2), .PIPE(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready_o[1]),
    .enq_data  (enq_data),
    .deq_valid (deq_valid_o[1]),
    .deq_ready (deq_ready),
    .deq_data  (deq_data_o[1]),
    .count     (count_o[1]),
    .free      (free_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  gpreg mq [2][$];
  int   last_ne [2];
  int   last_nd [2];
  gpreg cur_d [2];
  logic cur_fl;
  logic cur_rs;
  logic known = 1'b0;

  function automatic logic [1:0] pmask(input int n);
    return (n >= 2) ? 2'b11 : ((n == 1) ? 2'b01 : 2'b00);
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, then compare all
  // outputs against the model once combinational paths settle.
  task automatic apply(input int nv, input int nr, input gpreg d0, input gpreg d1,
                       input logic fl, input logic rs);
    rst         = rs;
    flush       = fl;
    enq_valid   = pmask(nv);
    deq_ready   = pmask(nr);
    enq_data[0] = d0;
    enq_data[1] = d1;
    cur_d[0]    = d0;
    cur_d[1]    = d1;
    cur_fl      = fl;
    cur_rs      = rs;
    #1;
    for (int k = 0; k < 2; k++) begin
      int         cnt;
      int         nd;
      int         ne;
      int         avail;
      logic [1:0] er;
      logic [1:0] dv;
      cnt = mq[k].size();
      nd  = 0;
      for (int i = 0; i < 2; i++) begin
        if (nd == i && i < cnt && deq_ready[i]) nd++;
      end
      avail = (D - cnt) + ((k == 1) ? nd : 0);
      ne    = 0;
      for (int i = 0; i < 2; i++) begin
        er[i] = (avail > i);
        dv[i] = (cnt > i);
        if (ne == i && enq_valid[i] && er[i]) ne++;
      end
      last_nd[k] = nd;
      last_ne[k] = ne;
      if (known) begin
        check("count", k, 32'(count_o[k]), 32'(cnt));
        check("free", k, 32'(free_o[k]), 32'(D - cnt));
        check("deq_valid", k, 32'(deq_valid_o[k]), 32'(dv));
        check("enq_ready", k, 32'(enq_ready_o[k]), 32'(er));
        for (int i = 0; i < 2; i++) begin
          if (i < cnt) check("deq_data", k, deq_data_o[k][i], mq[k][i]);
        end
        check("count_le_depth", k, 32'(count_o[k] <= 3'(D)), 32'd1);
      end
    end
  endtask

  // Clock edge plus model update.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (cur_rs || cur_fl) begin
        mq[k].delete();
      end else begin
        for (int i = 0; i < last_nd[k]; i++) void'(mq[k].pop_front());
        for (int i = 0; i < last_ne[k]; i++) mq[k].push_back(cur_d[i]);
      end
    end
    if (cur_rs) known = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    enq_valid   = '0;
    deq_ready   = '0;
    enq_data[0] = '0;
    enq_data[1] = '0;
    @(negedge clk);

    // Reset, then idle.
    apply(0, 0, 0, 0, 1'b0, 1'b1); tick();
    apply(0, 0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("rst_count", k, 32'(count_o[k]), 32'd0);
      check("rst_free", k, 32'(free_o[k]), 32'd6);
      check("rst_deq_valid", k, 32'(deq_valid_o[k]), 32'd0);
      check("rst_enq_ready", k, 32'(enq_ready_o[k]), 32'd3);
    end
    tick();

    // Fill with A..F, no dequeue.
    apply(2, 0, 32'hA, 32'hB, 1'b0, 1'b0); tick();
    apply(2, 0, 32'hC, 32'hD, 1'b0, 1'b0); tick();
    apply(2, 0, 32'hE, 32'hF, 1'b0, 1'b0); tick();
    apply(0, 0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("full_count", k, 32'(count_o[k]), 32'd6);
      check("full_enq_ready0", k, 32'(enq_ready_o[k][0]), 32'd0);
      check("full_head0", k, deq_data_o[k][0], 32'hA);
      check("full_head1", k, deq_data_o[k][1], 32'hB);
    end
    tick();

    // Full with both deq lanes ready and two enqueues offered.
    apply(2, 2, 32'h10, 32'h11, 1'b0, 1'b0);
    check("pipe_full_ready", 1, 32'(enq_ready_o[1]), 32'd3);
    check("nopipe_full_ready", 0, 32'(enq_ready_o[0]), 32'd0);
    tick();
    apply(0, 0, 0, 0, 1'b0, 1'b0);
    check("pipe_full_count", 1, 32'(count_o[1]), 32'd6);
    check("nopipe_full_count", 0, 32'(count_o[0]), 32'd4);
    check("after_full_head", 0, deq_data_o[0][0], 32'hC);
    tick();

    // Partial dequeue: dut0 down to 3, then 1-lane dequeue with 2 enqueues.
    apply(0, 1, 0, 0, 1'b0, 1'b0); tick();
    apply(2, 1, 32'h20, 32'h21, 1'b0, 1'b0);
    check("partial_count_before", 0, 32'(count_o[0]), 32'd3);
    tick();
    apply(0, 0, 0, 0, 1'b0, 1'b0);
    check("partial_count_after", 0, 32'(count_o[0]), 32'd4);
    tick();

    // Flush with simultaneous handshakes.
    apply(2, 2, 32'h30, 32'h31, 1'b1, 1'b0); tick();
    apply(0, 0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("flush_count", k, 32'(count_o[k]), 32'd0);
      check("flush_valid0", k, 32'(deq_valid_o[k][0]), 32'd0);
    end
    tick();
    apply(1, 0, 32'h55, 0, 1'b0, 1'b0);
    check("no_bypass", 0, 32'(deq_valid_o[0]), 32'd0);
    tick();
    apply(0, 0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("post_flush_valid", k, 32'(deq_valid_o[k]), 32'd1);
      check("post_flush_data", k, deq_data_o[k][0], 32'h55);
    end
    tick();

    // Wrap-around: alternate 2-in and 0-in while dequeuing one per cycle.
    for (int c = 0; c < 20; c++) begin
      apply((c % 2 == 0) ? 2 : 0, 1, $urandom, $urandom, 1'b0, 1'b0);
      tick();
    end

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 400; c++) begin
      apply($urandom_range(0, 2), $urandom_range(0, 2), $urandom, $urandom,
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 79) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_multi_queue
